// File: rtl/sr_arbiter.sv
// ------------------------------------------------------------------
// sr_arbiter: 4-way round-robin arbiter that loads one requester's word
// into an external shift register and strobes the output latch. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sr_arbiter #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [3:0]      i_req,
  input  logic [4*DW-1:0] i_data,
  input  logic            i_srbusy,
  output logic [3:0]      o_gnt,
  output logic            o_srload,
  output logic [DW-1:0]   o_srdata,
  output logic            o_latch,
  output logic [1:0]      o_owner,
  output logic            o_busy,
  output logic            o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Counter value seen during the last permitted WAIT cycle.
  localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [1:0]    last_winner_q, last_winner_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          srload_q, srload_d;
  logic [DW-1:0] srdata_q, srdata_d;
  logic          latch_q, latch_d;
  logic [1:0]    owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic          w_win_valid;
  logic [1:0]    w_win_idx;
  logic [1:0]    w_cand;
  logic [DW-1:0] w_win_data;

  // Scan from lowest to highest priority so the last hit is the winner;
  // offset 4 wraps to the previous winner itself (lowest priority).
  always_comb begin : p_rr_pick
    w_win_valid = 1'b0;
    w_win_idx   = 2'd0;
    w_cand      = 2'd0;
    for (int off = 4; off >= 1; off--) begin
      w_cand = last_winner_q + 2'(off);
      if (i_req[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign w_win_data = i_data[w_win_idx*DW +: DW];

  always_comb begin : p_next
    state_d       = state_q;
    last_winner_d = last_winner_q;
    wait_cnt_d    = wait_cnt_q;
    gnt_d         = 4'b0000;
    srload_d      = 1'b0;
    srdata_d      = srdata_q;
    latch_d       = 1'b0;
    owner_d       = owner_q;
    timeout_d     = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (w_win_valid && !i_srbusy) begin
          state_d       = ST_LOAD;
          gnt_d         = 4'b0001 << w_win_idx;
          srload_d      = 1'b1;
          srdata_d      = w_win_data;
          owner_d       = w_win_idx;
          last_winner_d = w_win_idx;
        end
      end
      ST_LOAD: begin
        state_d    = ST_WAIT;
        wait_cnt_d = 8'd0;
      end
      ST_WAIT: begin
        if (!i_srbusy) begin
          state_d = ST_LATCH;
          latch_d = 1'b1;
        end else if (wait_cnt_q == C_WAIT_LAST) begin
          state_d   = ST_LATCH;
          latch_d   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_LATCH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : p_regs
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      last_winner_q <= 2'd3;
      wait_cnt_q    <= 8'd0;
      gnt_q         <= 4'b0000;
      srload_q      <= 1'b0;
      srdata_q      <= '0;
      latch_q       <= 1'b0;
      owner_q       <= 2'd0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      wait_cnt_q    <= wait_cnt_d;
      gnt_q         <= gnt_d;
      srload_q      <= srload_d;
      srdata_q      <= srdata_d;
      latch_q       <= latch_d;
      owner_q       <= owner_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_srload  = srload_q;
  assign o_srdata  = srdata_q;
  assign o_latch   = latch_q;
  assign o_owner   = owner_q;
  assign o_busy    = busy_q;
  assign o_timeout = timeout_q;

endmodule

`default_nettype wire
